// File: rtl/uart_tx.sv
// uart_tx -- serial transmitter: start bit, 8 data bits LSB first, optional
// parity bit, one stop bit. Each bit is held for P clocks (P = prescale,
// with 0 treated as 1). Frame parameters are captured when a request is
// accepted in IDLE; requests made while a frame is in progress are dropped.
//
// Ports:
//   clk        in   system/UART clock, rising edge
//   rst        in   synchronous active-high reset
//   p_data     in   [7:0] byte to send, sampled on acceptance
//   data_valid in   single-cycle send request
//   par_en     in   1 = append parity bit, sampled on acceptance
//   par_typ    in   0 = even, 1 = odd parity, sampled on acceptance
//   prescale   in   [5:0] clocks per bit, sampled on acceptance
//   tx_out     out  registered serial line, idle high
//   busy       out  registered, high for the whole frame
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] p_data,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic [5:0] prescale,
  output logic       tx_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [2:0]  idx_inc;
  logic        tx_n, busy_n;
  logic        accept;
  logic        bit_end;
  logic        par_bit;

  logic [7:0]  data_lat;
  logic        pe_lat;
  logic        pt_lat;
  logic [5:0]  p_lat;

  assign accept  = (state == IDLE) && data_valid;
  assign bit_end = (cnt == (p_lat - 6'd1));
  assign idx_inc = idx + 3'd1;
  assign par_bit = (^data_lat) ^ pt_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      data_lat <= '0;
      pe_lat   <= 1'b0;
      pt_lat   <= 1'b0;
      p_lat    <= '0;
    end else begin
      state  <= state_n;
      tx_out <= tx_n;
      busy   <= busy_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      if (accept) begin
        data_lat <= p_data;
        pe_lat   <= par_en;
        pt_lat   <= par_typ;
        p_lat    <= (prescale == 6'd0) ? 6'd1 : prescale;
      end
    end
  end

  // tx_out/busy are registered, so each branch computes the line value for
  // the state being entered on this edge, not the current one.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 6'd1;
    idx_n   = idx;
    tx_n    = 1'b1;
    busy_n  = 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        busy_n = 1'b0;
        if (data_valid) begin
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = data_lat[0];
        end
      end
      DATA: begin
        tx_n = data_lat[idx];
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            idx_n = '0;
            if (pe_lat) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx_inc;
            tx_n  = data_lat[idx_inc];
          end
        end
      end
      PARITY: begin
        tx_n = par_bit;
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed and randomized frames checked cycle by cycle
// against a bit-list model of the serial frame.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic scramble_inputs();
    p_data   = 8'($urandom);
    par_en   = 1'($urandom);
    par_typ  = 1'($urandom);
    prescale = 6'($urandom);
  endtask

  // Must be called at a negedge. Issues one request and checks every cycle
  // of the frame plus the idle cycle after it; returns at that idle negedge.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] pre, input int inject_at,
                      input int abort_at, input string name);
    logic bits[$];
    int   p;
    int   len;
    p = (pre == 6'd0) ? 1 : int'(pre);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? ~(^d) : (^d));
    bits.push_back(1'b1);
    len = bits.size() * p;

    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = pre;
    data_valid = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      scramble_inputs();
      check($sformatf("%s_tx_c%0d", name, c), tx_out, bits[c / p]);
      check($sformatf("%s_busy_c%0d", name, c), busy, 1'b1);
      if (c == inject_at) data_valid = 1'b1;
      if (c == abort_at) begin
        rst        = 1'b1;
        data_valid = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        data_valid = 1'b0;
        check({name, "_abort_tx"}, tx_out, 1'b1);
        check({name, "_abort_busy"}, busy, 1'b0);
        @(negedge clk);
        check({name, "_post_tx"}, tx_out, 1'b1);
        check({name, "_post_busy"}, busy, 1'b0);
        return;
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    check({name, "_idle_tx"}, tx_out, 1'b1);
    check({name, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      scramble_inputs();
      check("gap_tx", tx_out, 1'b1);
      check("gap_busy", busy, 1'b0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    data_valid = 1'b1;
    p_data     = 8'h5A;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd2;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    rst        = 1'b0;
    data_valid = 1'b0;
    idle(2);

    send(8'hA5, 1'b0, 1'b0, 6'd8, -1, -1, "a5_p8");
    idle(2);
    send(8'h03, 1'b1, 1'b0, 6'd16, -1, -1, "03_even");
    idle(1);
    send(8'h03, 1'b1, 1'b1, 6'd16, -1, -1, "03_odd");
    idle(2);
    send(8'($urandom), 1'b0, 1'b0, 6'd8, 20, -1, "ignore");
    idle(3);
    // cycle 34 lies in data bit 3 (cycles 32..39) with P = 8
    send(8'($urandom), 1'b0, 1'b0, 6'd8, -1, 34, "abort");
    send(8'($urandom), 1'b1, 1'b0, 6'd8, -1, -1, "after_rst");
    idle(1);
    send(8'hFF, 1'b1, 1'b1, 6'd0, -1, -1, "p0");
    idle(1);
    send(8'h55, 1'b0, 1'b0, 6'd4, -1, -1, "b2b_55");
    send(8'hAA, 1'b0, 1'b0, 6'd4, -1, -1, "b2b_aa");
    idle(1);

    for (int k = 0; k < 10; k++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom),
           6'($urandom_range(0, 7)), -1, -1, $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 clk  input  1  system/UART clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 p_data  input  8  parallel byte to transmit; sampled on acceptance.
REQ-005 data_valid  input  1  single-cycle request to send p_data.
REQ-006 par_en  input  1  1 = parity bit inserted after data; sampled on acceptance.
REQ-007 par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-008 prescale  input  6  clocks per bit (P); sampled on acceptance; value 0 SHALL be treated as 1.
REQ-009 tx_out  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  registered; high while a frame is in progress.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-012 Acceptance SHALL occur only when state = IDLE and data_valid = 1; p_data, par_en, par_typ and prescale are then latched internally.
REQ-013 data_valid while state != IDLE SHALL be ignored (request dropped, no queuing).
REQ-014 On acceptance, next cycle: state = START, tx_out = 0, busy = 1 (latency 1 clock).
REQ-015 Each bit SHALL occupy exactly P consecutive clocks on tx_out, timed by a 6-bit edge counter running 0..P-1 and cleared at each bit boundary.
REQ-016 DATA SHALL send latched bits 0..7, LSB first; a 3-bit index advances when the edge counter reaches P-1; after bit 7 the next state is PARITY when latched par_en = 1, otherwise STOP.
REQ-017 PARITY bit SHALL equal XOR of the latched byte when par_typ = 0, or its inverse when par_typ = 1; it lasts P clocks, then STOP.
REQ-018 STOP SHALL drive tx_out = 1 for P clocks, then the state returns to IDLE with busy = 0.
REQ-019 Frame length SHALL be 10*P clocks without parity and 11*P clocks with parity, measured from the first START cycle.
REQ-020 In IDLE, tx_out SHALL be 1 and busy SHALL be 0.
REQ-021 Back-to-back frames: a request accepted in the first IDLE cycle after STOP produces a start bit on the following cycle, giving minimum 1 idle-high clock between frames.
REQ-022 Changes on p_data, par_en, par_typ or prescale during a frame SHALL NOT affect that frame.
REQ-023 With P = 1, the block SHALL emit one bit per clock with no skipped or doubled bits.

Reset
REQ-024 When rst = 1 at a clock edge, the next state SHALL be: state = IDLE, tx_out = 1, busy = 0, edge counter = 0, bit index = 0, latched registers = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately: tx_out = 1 on the next cycle, and no partial bits resume.
REQ-026 data_valid asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-027 Byte 0xA5, par_en = 0, prescale = 8 -> tx_out 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 8 clocks; busy high for 80 clocks.
REQ-028 Byte 0x03, par_en = 1, par_typ = 0, prescale = 16 -> parity bit 0; with par_typ = 1 -> parity bit 1; frame = 176 clocks.
REQ-029 Second data_valid pulse 20 clocks into a frame (prescale = 8) -> ignored; only one frame appears on tx_out.
REQ-030 rst asserted during DATA bit 3 -> the next cycle tx_out = 1 and busy = 0; a new request after reset produces a complete, correct frame.
REQ-031 prescale = 0, byte 0xFF, par_en = 1, par_typ = 1 -> 11-clock frame, parity bit 1 (treated as P = 1).
REQ-032 Two requests, the second issued in the first IDLE cycle after the first frame, byte 0x55 then 0xAA, prescale = 4 -> exactly 1 idle-high clock between frames, and both frames are correct.
